// File: rtl/axil_gpio_irq.sv
// AXI4-Lite GPIO block: registered outputs, 2-flop synchronised inputs, rising-edge interrupts.
// Define GPIO_IRQ_EN to build IRQ_EN/IRQ_STATUS/irq_o; otherwise they read 0 and irq_o is tied low.
module axil_gpio_irq #(
  parameter int unsigned NUM_IN     = 8,
  parameter int unsigned NUM_OUT    = 8,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  input  logic [NUM_IN-1:0]     gpio_in_i,
  output logic [NUM_OUT-1:0]    gpio_out_o,
  output logic                  irq_o
);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic {WIdle, WResp} wstate_e;
  typedef enum logic {RIdle, RData} rstate_e;

  wstate_e r_wstate, w_wstate_next;
  rstate_e r_rstate, w_rstate_next;

  logic               r_live;
  logic               r_aw_got, r_w_got;
  logic [3:0]         r_awaddr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic [NUM_OUT-1:0] r_dout;
  logic [NUM_IN-1:0]  r_sync1, r_sync2;
  logic [1:0]         r_bresp, r_rresp;
  logic [31:0]        r_rdata;

  logic               w_aw_hs, w_w_hs, w_ar_hs, w_wr_fire, w_wr_ok;
  logic [3:0]         w_waddr, w_wstrb;
  logic [31:0]        w_wdata, w_wmask;
  logic [NUM_OUT-1:0] w_dout_next;
  logic [31:0]        w_dout32, w_din32, w_en32, w_st32, w_rdata;
  logic               w_unused;

  assign w_unused = ^{s_axil_awaddr[ADDR_WIDTH-1:4], s_axil_araddr[ADDR_WIDTH-1:4], w_wdata};

  // Ready only once reset has been released for at least one edge.
  assign s_axil_awready = r_live & (r_wstate == WIdle) & ~r_aw_got;
  assign s_axil_wready  = r_live & (r_wstate == WIdle) & ~r_w_got;
  assign s_axil_arready = r_live & (r_rstate == RIdle);
  assign s_axil_bvalid  = (r_wstate == WResp);
  assign s_axil_rvalid  = (r_rstate == RData);
  assign s_axil_bresp   = r_bresp;
  assign s_axil_rresp   = r_rresp;
  assign s_axil_rdata   = r_rdata;
  assign gpio_out_o     = r_dout;

  always_comb begin
    w_aw_hs   = s_axil_awvalid & s_axil_awready;
    w_w_hs    = s_axil_wvalid & s_axil_wready;
    w_ar_hs   = s_axil_arvalid & s_axil_arready;
    w_waddr   = r_aw_got ? r_awaddr : s_axil_awaddr[3:0];
    w_wdata   = r_w_got ? r_wdata : s_axil_wdata;
    w_wstrb   = r_w_got ? r_wstrb : s_axil_wstrb;
    w_wmask   = {{8{w_wstrb[3]}}, {8{w_wstrb[2]}}, {8{w_wstrb[1]}}, {8{w_wstrb[0]}}};
    w_wr_fire = (r_wstate == WIdle) & (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);
    w_wr_ok   = w_wr_fire & (w_waddr[1:0] == 2'b00);

    w_wstate_next = r_wstate;
    case (r_wstate)
      WIdle:   if (w_wr_fire) w_wstate_next = WResp;
      WResp:   if (s_axil_bready) w_wstate_next = WIdle;
      default: w_wstate_next = WIdle;
    endcase

    w_rstate_next = r_rstate;
    case (r_rstate)
      RIdle:   if (w_ar_hs) w_rstate_next = RData;
      RData:   if (s_axil_rready) w_rstate_next = RIdle;
      default: w_rstate_next = RIdle;
    endcase
  end

  always_comb begin
    w_dout_next = r_dout;
    if (w_wr_ok && (w_waddr[3:2] == 2'd0)) begin
      for (int i = 0; i < int'(NUM_OUT); i++) begin
        if (w_wmask[i]) w_dout_next[i] = w_wdata[i];
      end
    end
  end

  always_comb begin
    w_dout32 = '0;
    w_dout32[NUM_OUT-1:0] = r_dout;
    w_din32 = '0;
    w_din32[NUM_IN-1:0] = r_sync2;
    w_rdata = '0;
    if (s_axil_araddr[1:0] == 2'b00) begin
      case (s_axil_araddr[3:2])
        2'd0:    w_rdata = w_dout32;
        2'd1:    w_rdata = w_din32;
        2'd2:    w_rdata = w_en32;
        default: w_rdata = w_st32;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_live   <= 1'b0;
      r_wstate <= WIdle;
      r_rstate <= RIdle;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RespOkay;
      r_rresp  <= RespOkay;
      r_rdata  <= '0;
      r_dout   <= '0;
      r_sync1  <= '0;
      r_sync2  <= '0;
    end else begin
      r_live   <= 1'b1;
      r_wstate <= w_wstate_next;
      r_rstate <= w_rstate_next;
      // A beat accepted in the firing cycle is consumed directly, never parked.
      if (w_wr_fire) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
        r_bresp  <= w_wr_ok ? RespOkay : RespSlvErr;
      end else begin
        if (w_aw_hs) begin
          r_aw_got <= 1'b1;
          r_awaddr <= s_axil_awaddr[3:0];
        end
        if (w_w_hs) begin
          r_w_got <= 1'b1;
          r_wdata <= s_axil_wdata;
          r_wstrb <= s_axil_wstrb;
        end
      end
      r_dout  <= w_dout_next;
      r_sync1 <= gpio_in_i;
      r_sync2 <= r_sync1;
      if (w_ar_hs) begin
        r_rdata <= w_rdata;
        r_rresp <= (s_axil_araddr[1:0] == 2'b00) ? RespOkay : RespSlvErr;
      end
    end
  end

`ifdef GPIO_IRQ_EN
  logic [NUM_IN-1:0] r_prev, r_en, r_status;
  logic [NUM_IN-1:0] w_clr, w_en_next;
  logic              r_irq;

  always_comb begin
    w_clr     = '0;
    w_en_next = r_en;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (w_wr_ok && (w_waddr[3:2] == 2'd3) && w_wmask[i]) w_clr[i] = w_wdata[i];
      if (w_wr_ok && (w_waddr[3:2] == 2'd2) && w_wmask[i]) w_en_next[i] = w_wdata[i];
    end
    w_en32 = '0;
    w_en32[NUM_IN-1:0] = r_en;
    w_st32 = '0;
    w_st32[NUM_IN-1:0] = r_status;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prev   <= '0;
      r_en     <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_prev   <= r_sync2;
      r_en     <= w_en_next;
      // New edge is OR-ed in after the clear so a coincident set wins.
      r_status <= (r_status & ~w_clr) | (r_sync2 & ~r_prev);
      r_irq    <= |(r_status & r_en);
    end
  end

  assign irq_o = r_irq;
`else
  assign w_en32 = '0;
  assign w_st32 = '0;
  assign irq_o  = 1'b0;
`endif

endmodule

// File: doc/axil_gpio_irq.md
AXIL_GPIO_IRQ -- requirements
Module: axil_gpio_irq

Interface
REQ-001 The block SHALL have parameter NUM_IN, default 8, the number of GPIO inputs (legal range 1..32).
REQ-002 The block SHALL have parameter NUM_OUT, default 8, the number of GPIO outputs (legal range 1..32).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 32, the AXI-Lite address width; data width is fixed at 32.
REQ-004 The block SHALL have port clk_i  in  1  system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_ni  in  1  reset, asynchronous assertion, active-low.
REQ-006 The block SHALL have ports s_axil_aw{addr,valid,ready}  in/in/out  ADDR_WIDTH/1/1  write address channel.
REQ-007 The block SHALL have ports s_axil_w{data,strb,valid,ready}  in/in/in/out  32/4/1/1  write data channel.
REQ-008 The block SHALL have ports s_axil_b{resp,valid,ready}  out/out/in  2/1/1  write response channel.
REQ-009 The block SHALL have ports s_axil_ar{addr,valid,ready}  in/in/out  ADDR_WIDTH/1/1  read address channel.
REQ-010 The block SHALL have ports s_axil_r{data,resp,valid,ready}  out/out/out/in  32/2/1/1  read data channel.
REQ-011 The block SHALL have port gpio_in_i  in  NUM_IN  asynchronous GPIO inputs.
REQ-012 The block SHALL have port gpio_out_o  out  NUM_OUT  registered GPIO outputs.
REQ-013 The block SHALL have port irq_o  out  1  level interrupt, registered.

Function
REQ-014 Register map, offset = addr[3:0] with addr[ADDR_WIDTH-1:4] ignored: 0x0 DATA_OUT RW, 0x4 DATA_IN RO, 0x8 IRQ_EN RW, 0xC IRQ_STATUS RW1C; bits above NUM_OUT/NUM_IN read 0 and ignore writes.
REQ-015 Unaligned offsets (addr[1:0] != 0) SHALL return SLVERR (2'b10), with no register update and rdata 0; all other accesses return OKAY.
REQ-016 Write FSM: W_IDLE -> W_RESP once both AW and W are captured, in either order or in the same cycle; awready/wready high in W_IDLE only while their own beat is not yet captured.
REQ-017 Register update occurs on the W_IDLE->W_RESP transition, per-byte per wstrb; bvalid rises the next cycle and holds until bready, then back to W_IDLE; one write outstanding.
REQ-018 Read FSM: R_IDLE (arready=1) -> R_DATA on arvalid, rdata sampled at acceptance; rvalid held with stable rdata/rresp until rready, then R_IDLE; one read outstanding.
REQ-019 Read and write FSMs SHALL operate independently; a same-cycle read of a register being written returns the pre-write value.
REQ-020 gpio_in_i SHALL pass a 2-flop synchroniser; DATA_IN reflects a pin change 2 cycles after the first sampling edge.
REQ-021 Rising edge of synchronised bit i SHALL set IRQ_STATUS[i] one cycle after DATA_IN[i] updates, regardless of IRQ_EN.
REQ-022 Writing 1 to IRQ_STATUS[i] clears it; on a same-cycle clear and new edge, set wins.
REQ-023 irq_o = registered OR of (IRQ_STATUS & IRQ_EN), one cycle after either term changes.
REQ-024 gpio_out_o SHALL equal DATA_OUT[NUM_OUT-1:0] directly from the register, no extra latency.

Reset
REQ-025 On rst_ni low, asynchronously: DATA_OUT, IRQ_EN, IRQ_STATUS, synchroniser and edge flops = 0; FSMs in IDLE; gpio_out_o, irq_o, bvalid, rvalid, bresp, rresp, rdata = 0; awready = wready = arready = 1 only after reset release.
REQ-026 Reset mid-transaction SHALL abort it with no response and no register update.

Configuration
REQ-027 Macro GPIO_IRQ_EN defined: REQ-021..023 implemented.
REQ-028 GPIO_IRQ_EN undefined: no edge logic, IRQ_EN/IRQ_STATUS read 0 with OKAY and ignore writes, irq_o tied 0.

Verification
REQ-029 Write 0xA5 to 0x0 with wstrb=0x1, AW one cycle before W -> bresp OKAY, gpio_out_o=0xA5 (NUM_OUT=8); read 0x0 -> 0x000000A5.
REQ-030 gpio_in_i 0x00->0x81 at cycle t -> DATA_IN reads 0x81 from t+2; IRQ_STATUS=0x81 at t+3; with IRQ_EN=0x01, irq_o=1 at t+4.
REQ-031 Write 0x1 to 0xC on the same cycle that bit 0 rises again -> IRQ_STATUS[0] stays 1, irq_o stays 1.
REQ-032 Read 0x6 -> rresp SLVERR, rdata 0; write 0x2 to 0x0 -> bresp SLVERR, gpio_out_o unchanged.
REQ-033 bready/rready held low for 5 cycles -> bvalid/rvalid and data stable; awready/arready stay 0 until the handshake completes.
REQ-034 Assert rst_ni low while bvalid=1 -> all outputs 0 immediately, no B beat after release; rebuilt without GPIO_IRQ_EN -> irq_o constant 0 through REQ-030.
